// File: rtl/otp_pkg.sv
// Shared OTP array bias levels, mode codes and read-sequencer state encoding.
// Imported by both the programming FSM and the read sequencer.
package otp_pkg;

  localparam logic [1:0] PL_V_GND  = 2'b00;
  localparam logic [1:0] PL_V_MID  = 2'b01;
  localparam logic [1:0] PL_V_READ = 2'b10;
  localparam logic [1:0] PL_V_HIGH = 2'b11;

  localparam logic BL_V_GND   = 1'b0;
  localparam logic BL_V_HIGH  = 1'b1;
  localparam logic WLN_V_GND  = 1'b1;
  localparam logic WLN_V_MID  = 1'b0;
  localparam logic WLP_V_MID  = 1'b1;
  localparam logic WLP_V_HIGH = 1'b0;

  typedef enum logic [1:0] {
    OTP_MODE_IDLE = 2'd0,
    OTP_MODE_PROG = 2'd1,
    OTP_MODE_READ = 2'd2
  } otp_mode_e;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_PL_UP,
    RD_SETTLE,
    RD_ROW_ON,
    RD_SENSE,
    RD_SAMPLE,
    RD_PL_DOWN,
    RD_RESP
  } rd_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/otp_read_sequencer_if.sv
// Request/response channel of the OTP read sequencer.
// The column field is one bit wider than needed so out-of-range columns can be requested and rejected.
interface otp_read_sequencer_if #(
  parameter int unsigned A = 8,
  parameter int unsigned B = 8
) ();
  localparam int unsigned CW = $clog2(B) + 1;

  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] column;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [A-1:0]  data_out;
  logic          rsp_err;

  modport master (
    output req_valid, column, rsp_ready,
    input  req_ready, rsp_valid, data_out, rsp_err
  );

  modport slave (
    input  req_valid, column, rsp_ready,
    output req_ready, rsp_valid, data_out, rsp_err
  );
endinterface

// File: rtl/otp_wait_counter.sv
// Load-and-count-down delay counter; done_c is high in the last cycle of a loaded wait.
module otp_wait_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_c = (cnt_q == W'(1));

endmodule

// File: rtl/otp_read_sequencer.sv
// Reads one OTP column: raises the column PL to read level, opens each row's WLN in turn,
// captures the sense-amp bit per row and returns the word on a valid/ready response.
module otp_read_sequencer
  import otp_pkg::*;
#(
  parameter int unsigned A             = 8,
  parameter int unsigned B             = 8,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned SENSE_CYCLES  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  otp_read_sequencer_if.slave  bus,
  input  logic [B-1:0]         sense_in,
  output logic [2*B-1:0]       PL,
  output logic [B-1:0]         BL,
  output logic [A-1:0]         WLN,
  output logic [A-1:0]         WLP,
  output logic                 read_active
);

  localparam int unsigned CW   = $clog2(B) + 1;
  localparam int unsigned RW   = $clog2(A) + 1;
  localparam int unsigned CNTW = $clog2(max_u(SETTLE_CYCLES, SENSE_CYCLES) + 1);

  rd_state_e      state_q, state_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CW-1:0]  col_q, col_d;
  logic [2*B-1:0] pl_q, pl_d;
  logic [A-1:0]   wln_q, wln_d;
  logic           ra_q, ra_d;
  logic [A-1:0]   data_q, data_d;
  logic           err_q, err_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           req_ready_q, req_ready_d;

  logic            cnt_load_c;
  logic [CNTW-1:0] cnt_val_c;
  logic            cnt_done_c;
  logic            sense_bit_c;

  otp_wait_counter #(.W(CNTW)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load_c),
    .load_val (cnt_val_c),
    .done_c   (cnt_done_c)
  );

  // Sense-amp output of the captured column.
  always_comb begin
    sense_bit_c = 1'b0;
    for (int unsigned c = 0; c < B; c++) begin
      if (col_q == CW'(c)) sense_bit_c = sense_in[c];
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    pl_d       = pl_q;
    wln_d      = wln_q;
    ra_d       = ra_q;
    data_d     = data_q;
    err_d      = err_q;
    cnt_load_c = 1'b0;
    cnt_val_c  = '0;

    case (state_q)
      RD_IDLE: begin
        if (bus.req_valid) begin
          col_d = bus.column;
          if (bus.column >= CW'(B)) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = RD_RESP;
          end else begin
            err_d   = 1'b0;
            row_d   = '0;
            state_d = RD_PL_UP;
          end
        end
      end
      RD_PL_UP: begin
        for (int unsigned c = 0; c < B; c++) begin
          if (col_q == CW'(c)) pl_d[2*c +: 2] = PL_V_READ;
        end
        ra_d       = 1'b1;
        cnt_load_c = 1'b1;
        cnt_val_c  = CNTW'(SETTLE_CYCLES);
        state_d    = RD_SETTLE;
      end
      RD_SETTLE: begin
        if (cnt_done_c) state_d = RD_ROW_ON;
      end
      RD_ROW_ON: begin
        for (int unsigned r = 0; r < A; r++) begin
          if (row_q == RW'(r)) wln_d[r] = WLN_V_MID;
        end
        cnt_load_c = 1'b1;
        cnt_val_c  = CNTW'(SENSE_CYCLES);
        state_d    = RD_SENSE;
      end
      RD_SENSE: begin
        if (cnt_done_c) state_d = RD_SAMPLE;
      end
      RD_SAMPLE: begin
        for (int unsigned r = 0; r < A; r++) begin
          if (row_q == RW'(r)) begin
            data_d[r] = sense_bit_c;
            wln_d[r]  = WLN_V_GND;
          end
        end
        if (row_q == RW'(A - 1)) begin
          state_d = RD_PL_DOWN;
        end else begin
          row_d   = row_q + RW'(1);
          state_d = RD_ROW_ON;
        end
      end
      RD_PL_DOWN: begin
        pl_d    = {B{PL_V_GND}};
        ra_d    = 1'b0;
        state_d = RD_RESP;
      end
      RD_RESP: begin
        if (bus.rsp_ready) state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase

    req_ready_d = (state_d == RD_IDLE);
    rsp_valid_d = (state_d == RD_RESP);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RD_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      pl_q        <= {B{PL_V_GND}};
      wln_q       <= {A{WLN_V_GND}};
      ra_q        <= 1'b0;
      data_q      <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      pl_q        <= pl_d;
      wln_q       <= wln_d;
      ra_q        <= ra_d;
      data_q      <= data_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign PL            = pl_q;
  assign BL            = {B{BL_V_GND}};
  assign WLN           = wln_q;
  assign WLP           = {A{WLP_V_MID}};
  assign read_active   = ra_q;
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.data_out  = data_q;
  assign bus.rsp_err   = err_q;

  // Array bias safety: decoded views of the pin state for the invariants below.
  logic [B-1:0] pl_read_c, pl_bad_c;
  logic [A-1:0] wln_mid_c;

  always_comb begin
    pl_read_c = '0;
    pl_bad_c  = '0;
    for (int unsigned c = 0; c < B; c++) begin
      pl_read_c[c] = (pl_q[2*c +: 2] == PL_V_READ);
      pl_bad_c[c]  = (pl_q[2*c +: 2] == PL_V_MID) || (pl_q[2*c +: 2] == PL_V_HIGH);
    end
    wln_mid_c = ~(wln_q ^ {A{WLN_V_MID}});
  end

  a_wln_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(wln_mid_c));
  a_wln_bias:   assert property (@(posedge clk) disable iff (!reset)
                                 (|wln_mid_c) |-> (ra_q && (|pl_read_c)));
  a_pl_levels:  assert property (@(posedge clk) disable iff (!reset)
                                 (pl_bad_c == '0) && $onehot0(pl_read_c));
  a_static:     assert property (@(posedge clk) disable iff (!reset)
                                 (BL == {B{BL_V_GND}}) && (WLP == {A{WLP_V_MID}}));

endmodule
